press_ctrl: RTL and testbench



---
 rtl/press_ctrl_pkg.sv | 25 ++
 rtl/btn_debounce.sv | 52 +++++
 rtl/press_ctrl.sv | 113 +++++++++++
 tb/tb_press_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/press_ctrl_pkg.sv
// Shared definitions for the push-button gesture sequencer: default timing
// constants and the gesture FSM state encoding.
package press_ctrl_pkg;

  localparam int DEF_DEB_CYC  = 4;
  localparam int DEF_LONG_CYC = 20;
  localparam int DEF_DBL_GAP  = 10;
  localparam int DEF_CNT_W    = 8;

  // Fixed encodings so the enum below and any observer agree on state values.
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HELD  = 3'd1;
  localparam logic [2:0] S_LONG  = 3'd2;
  localparam logic [2:0] S_WAIT2 = 3'd3;
  localparam logic [2:0] S_LOCK  = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = S_IDLE,
    HELD  = S_HELD,
    LONG  = S_LONG,
    WAIT2 = S_WAIT2,
    LOCK  = S_LOCK
  } state_e;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, debounce counter and edge detection for one raw
// button level. rise/fall are combinational and last exactly one cycle.
module btn_debounce #(
  parameter int DEB_CYC = 4,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_d,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYC - 1);

  logic             sync_1;
  logic             btn_s;
  logic             btn_q;
  logic [CNT_W-1:0] deb_cnt;

  // NOTE: every register here is assigned with <= so all flops sample the
  // pre-edge values together; blocking assignments would chain them.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      btn_s   <= 1'b0;
      btn_d   <= 1'b0;
      btn_q   <= 1'b0;
      deb_cnt <= '0;
    end else begin
      sync_1 <= btn;
      btn_s  <= sync_1;
      btn_q  <= btn_d;
      // btn_d only follows after DEB_CYC consecutive differing samples.
      if (btn_s != btn_d) begin
        if (deb_cnt == DEB_LAST) begin
          btn_d   <= btn_s;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + CNT_W'(1);
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

  assign rise = btn_d & ~btn_q;
  assign fall = ~btn_d & btn_q;

endmodule

// File: rtl/press_ctrl.sv
// Push-button gesture sequencer: classifies debounced presses into short
// press, long press and double click, each reported as a one-cycle pulse.
module press_ctrl
  import press_ctrl_pkg::*;
#(
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter int DBL_GAP  = DEF_DBL_GAP,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic btn_level,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_GAP - 1);

  logic             rise;
  logic             fall;
  state_e           state;
  state_e           state_nx;
  logic [CNT_W-1:0] gcnt;
  logic [CNT_W-1:0] gcnt_nx;
  logic             short_nx;
  logic             long_nx;
  logic             dbl_nx;

  btn_debounce #(
    .DEB_CYC (DEB_CYC),
    .CNT_W   (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .btn_d (btn_level),
    .rise  (rise),
    .fall  (fall)
  );

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    short_nx = 1'b0;
    long_nx  = 1'b0;
    dbl_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_nx = HELD;
          gcnt_nx  = '0;
        end
      end
      HELD: begin
        // A release on the terminal count still counts as a short press.
        if (fall) begin
          state_nx = WAIT2;
          gcnt_nx  = '0;
        end else if (gcnt == LONG_LAST) begin
          state_nx = LONG;
          long_nx  = 1'b1;
        end else begin
          gcnt_nx = gcnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (fall) state_nx = IDLE;
      end
      WAIT2: begin
        // A second press on the terminal count still counts as a double click.
        if (rise) begin
          state_nx = LOCK;
          dbl_nx   = 1'b1;
        end else if (gcnt == DBL_LAST) begin
          state_nx = IDLE;
          short_nx = 1'b1;
        end else begin
          gcnt_nx = gcnt + CNT_W'(1);
        end
      end
      LOCK: begin
        if (fall) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      gcnt         <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nx;
      gcnt         <= gcnt_nx;
      short_press  <= short_nx;
      long_press   <= long_nx;
      double_click <= dbl_nx;
      busy         <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_press_ctrl.sv
// Self-checking bench for press_ctrl: a timestamp-based reference model checks
// every cycle, a gesture table checks pulse counts, and hand sequences check
// latencies, tie rules and reset mid-gesture.
module tb_press_ctrl;
  import press_ctrl_pkg::*;

  localparam int DEB_CYC  = DEF_DEB_CYC;
  localparam int LONG_CYC = DEF_LONG_CYC;
  localparam int DBL_GAP  = DEF_DBL_GAP;
  localparam int CNT_W    = DEF_CNT_W;

  logic clk = 1'b0;
  logic rst;
  logic btn;
  logic btn_level, short_press, long_press, double_click, busy;

  press_ctrl #(
    .DEB_CYC  (DEB_CYC),
    .LONG_CYC (LONG_CYC),
    .DBL_GAP  (DBL_GAP),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn          (btn),
    .btn_level    (btn_level),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  // Reference model: gesture phases timed by elapsed edges since the last
  // phase change; debounce judged from a window of synchronized samples.
  localparam int PH_IDLE = 0, PH_DOWN = 1, PH_DOWN_LONG = 2, PH_GAP = 3, PH_DOWN2 = 4;

  bit m_s1, m_s2, m_bd, m_bq;
  bit m_hist[$];
  int m_phase = PH_IDLE;
  int m_t0;
  bit m_short, m_long, m_dbl;

  // Observed-event bookkeeping, written only by the monitor.
  int n_short = 0, n_long = 0, n_dbl = 0, n_lvl = 0;
  int short_edge = -1, long_edge = -1, held_edge = -1, wait2_edge = -1, lvl_edge = -1;
  logic       prev_lvl = 1'b0;
  logic [2:0] prev_state = S_IDLE;

  always @(posedge clk) begin
    bit m_rise, m_fall, bs_pre, all_diff;
    edge_n++;
    m_rise  = m_bd & ~m_bq;
    m_fall  = ~m_bd & m_bq;
    m_short = 1'b0;
    m_long  = 1'b0;
    m_dbl   = 1'b0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_bd = 0; m_bq = 0;
      m_hist.delete();
      m_phase = PH_IDLE;
    end else begin
      case (m_phase)
        PH_IDLE: if (m_rise) begin m_phase = PH_DOWN; m_t0 = edge_n; end
        PH_DOWN: begin
          if (m_fall) begin m_phase = PH_GAP; m_t0 = edge_n; end
          else if (edge_n - m_t0 == LONG_CYC) begin m_phase = PH_DOWN_LONG; m_long = 1; end
        end
        PH_DOWN_LONG: if (m_fall) m_phase = PH_IDLE;
        PH_GAP: begin
          if (m_rise) begin m_phase = PH_DOWN2; m_dbl = 1; end
          else if (edge_n - m_t0 == DBL_GAP) begin m_phase = PH_IDLE; m_short = 1; end
        end
        PH_DOWN2: if (m_fall) m_phase = PH_IDLE;
        default: m_phase = PH_IDLE;
      endcase
      bs_pre = m_s2;
      m_bq   = m_bd;
      m_hist.push_back(bs_pre);
      if (m_hist.size() > DEB_CYC) void'(m_hist.pop_front());
      all_diff = (m_hist.size() == DEB_CYC);
      foreach (m_hist[i]) if (m_hist[i] == m_bd) all_diff = 0;
      if (all_diff) m_bd = bs_pre;
      m_s2 = m_s1;
      m_s1 = btn;
    end
    #1;
    check("model_btn_level", btn_level, m_bd);
    check("model_short_press", short_press, m_short);
    check("model_long_press", long_press, m_long);
    check("model_double_click", double_click, m_dbl);
    check("model_busy", busy, m_phase != PH_IDLE);
    if (short_press) begin n_short++; short_edge = edge_n; end
    if (long_press) begin n_long++; long_edge = edge_n; end
    if (double_click) n_dbl++;
    if (btn_level && !prev_lvl) begin n_lvl++; lvl_edge = edge_n; end
    if (dut.state == S_HELD && prev_state != S_HELD) held_edge = edge_n;
    if (dut.state == S_WAIT2 && prev_state != S_WAIT2) wait2_edge = edge_n;
    prev_lvl   = btn_level;
    prev_state = dut.state;
  end

  task automatic hold(input bit b, input int n);
    btn = b;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    string name;
    int    hi1, lo1, hi2;
    int    exp_short, exp_long, exp_dbl, exp_lvl;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, l0, d0, v0, k, cnt;

    vecs[0]  = '{"short",       10, 30,  0, 1, 0, 0, 1};
    vecs[1]  = '{"long",        40, 30,  0, 0, 1, 0, 1};
    vecs[2]  = '{"double",       5,  4,  5, 0, 0, 1, 2};
    vecs[3]  = '{"tie_long",    LONG_CYC, 30, 0, 1, 0, 0, 1};
    vecs[4]  = '{"over_long",   LONG_CYC + 1, 30, 0, 0, 1, 0, 1};
    vecs[5]  = '{"tie_gap",      5, DBL_GAP, 5, 0, 0, 1, 2};
    vecs[6]  = '{"over_gap",     5, DBL_GAP + 1, 5, 2, 0, 0, 2};
    vecs[7]  = '{"glitch1",      1, 10,  0, 0, 0, 0, 0};
    vecs[8]  = '{"glitch2",      2, 10,  0, 0, 0, 0, 0};
    vecs[9]  = '{"glitch3",      3, 10,  0, 0, 0, 0, 0};
    vecs[10] = '{"stable4",      4, 30,  0, 1, 0, 0, 1};
    vecs[11] = '{"long_then_tap", 40, 4, 5, 1, 1, 0, 2};

    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_btn_level", btn_level, 0);
    check("rst_short", short_press, 0);
    check("rst_long", long_press, 0);
    check("rst_double", double_click, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dut.state, S_IDLE);
    rst = 1'b0;
    hold(0, 5);

    foreach (vecs[i]) begin
      s0 = n_short; l0 = n_long; d0 = n_dbl; v0 = n_lvl;
      hold(1, vecs[i].hi1);
      hold(0, vecs[i].lo1);
      if (vecs[i].hi2 > 0) hold(1, vecs[i].hi2);
      hold(0, 40);
      check({vecs[i].name, "_short_cnt"}, n_short - s0, vecs[i].exp_short);
      check({vecs[i].name, "_long_cnt"}, n_long - l0, vecs[i].exp_long);
      check({vecs[i].name, "_dbl_cnt"}, n_dbl - d0, vecs[i].exp_dbl);
      check({vecs[i].name, "_lvl_rises"}, n_lvl - v0, vecs[i].exp_lvl);
      check({vecs[i].name, "_busy_end"}, busy, 0);
    end

    // Short press latency from WAIT2 entry.
    hold(1, 10);
    hold(0, 30);
    check("short_latency", short_edge - wait2_edge, DBL_GAP);

    // Long press latency from HELD entry.
    hold(1, 40);
    check("long_latency", long_edge - held_edge, LONG_CYC);
    hold(0, 40);

    // btn_level follows at edge 2+DEB_CYC, counting the sampling edge as 1.
    k = edge_n + 1;
    hold(1, 10);
    check("level_latency", lvl_edge, k + DEB_CYC + 1);
    hold(0, 40);

    // Reset mid-gesture, button kept pressed through and after reset.
    btn = 1'b1;
    cnt = 0;
    while (dut.state != S_HELD && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("reach_held", dut.state, S_HELD);
    hold(1, 5);
    s0 = n_short; l0 = n_long; d0 = n_dbl;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_btn_level", btn_level, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", dut.state, S_IDLE);
    check("midrst_no_pulse", (n_short - s0) + (n_long - l0) + (n_dbl - d0), 0);
    rst = 1'b0;
    k = edge_n + 1;
    hold(1, 40);
    check("postrst_level_latency", lvl_edge, k + DEB_CYC + 1);
    check("postrst_long_cnt", n_long - l0, 1);
    check("postrst_long_latency", long_edge - held_edge, LONG_CYC);
    check("postrst_short_cnt", n_short - s0, 0);
    hold(0, 40);

    // Random gestures with occasional resets, checked by the model each cycle.
    repeat (150) begin
      if ($urandom_range(0, 30) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst = 1'b0;
      end
      hold($urandom_range(0, 1) == 1, $urandom_range(1, 25));
    end
    hold(0, 40);
    check("random_busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
